// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator tile: FSM state type, default
// widths, product sign extension and the signed saturation limits.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } mac_state_e;

    localparam int PROD_W_DEF    = 16;
    localparam int ACC_W_DEF     = 24;
    localparam int BLOCK_LEN_DEF = 4;

    // Widest accumulator the helpers support; callers truncate to their width.
    localparam int MAX_W = 64;

    // Sign-extend the low pw bits of p across the full MAX_W word.
    function automatic logic [MAX_W-1:0] sext_prod(input logic [MAX_W-1:0] p,
                                                   input int pw);
        logic [MAX_W-1:0] r;
        logic             s;
        r = p;
        s = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == pw - 1) s = p[i];
        end
        for (int i = 0; i < MAX_W; i++) begin
            if (i >= pw) r[i] = s;
        end
        return r;
    endfunction

    // Largest positive value of a w-bit two's complement number: 2^(w-1)-1.
    function automatic logic [MAX_W-1:0] sat_max(input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Most negative value of a w-bit two's complement number: -2^(w-1).
    function automatic logic [MAX_W-1:0] sat_min(input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == w - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / byte-out handshake bundle of the MAC accumulator.
// slave: the accumulator side; master: the driver/sink side.
interface mac_accumulator_if #(
    parameter int PROD_W = 16
) ();
    logic signed [PROD_W-1:0] prod_i;
    logic                     prod_valid_i;
    logic                     prod_ready_o;
    logic                     clear_i;
    logic [7:0]               byte_o;
    logic                     byte_valid_o;
    logic                     byte_ready_i;
    logic                     ovf_o;
    logic                     busy_o;

    modport slave (
        input  prod_i, prod_valid_i, clear_i, byte_ready_i,
        output prod_ready_o, byte_o, byte_valid_o, ovf_o, busy_o
    );

    modport master (
        output prod_i, prod_valid_i, clear_i, byte_ready_i,
        input  prod_ready_o, byte_o, byte_valid_o, ovf_o, busy_o
    );
endinterface

// File: rtl/mac_accumulator_byte_serializer.sv
// Byte serializer: captures a finished ACC_W-bit sum plus its overflow flag
// and presents it LS byte first over a registered valid/ready port.
module byte_serializer #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [ACC_W-1:0] data_i,
    input  logic             ovf_i,
    input  logic             ready_i,
    output logic [7:0]       byte_o,
    output logic             valid_o,
    output logic             ovf_o,
    output logic             done_o
);
    localparam int NBYTES = ACC_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [ACC_W-1:0] sreg_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             ovf_q;
    logic             xfer;
    logic             last;

    assign xfer   = valid_q & ready_i;
    assign last   = (idx_q == IDX_W'(NBYTES - 1));
    // Last byte accepted this cycle: the FSM returns to IDLE on this edge.
    assign done_o = xfer & last;

    assign byte_o  = sreg_q[7:0];
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

    // Load a new result, shift one byte per accepted handshake, close after NBYTES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear_i) begin
            sreg_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load_i) begin
            sreg_q  <= data_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
            ovf_q   <= ovf_i;
        end else if (xfer) begin
            sreg_q <= sreg_q >> 8;
            if (last) begin
                idx_q   <= '0;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// MAC accumulator: sums BLOCK_LEN signed products into an ACC_W-bit
// accumulator, then drains the sum byte-serially with a sticky per-block
// signed-overflow flag.
// Build option MAC_SATURATE_EN: when defined the accumulator clamps to the
// signed limits on overflow and holds there until the block ends; when
// undefined it wraps in two's complement. ovf_o is raised in both builds.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,   // multiple of 8, >= PROD_W, <= MAX_W
    parameter int BLOCK_LEN = BLOCK_LEN_DEF // 1..255
) (
    input  logic              clk,
    input  logic              rst,
    mac_accumulator_if.slave  mac_if
);
    mac_state_e              state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] prod_ext;
    logic [7:0]              cnt_q;
    logic                    ovf_blk_q;
    logic                    ovf_blk_d;
    logic                    add_ovf;
    logic                    prod_ready;
    logic                    accept;
    logic                    final_acc;
    logic                    ser_load;
    logic                    ser_done;

    // Signed add with overflow detect; result is {overflow, sum}.
    function automatic logic [ACC_W:0] add_sat(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W-1:0] s;
        logic                    o;
        s = a + b;
        o = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
`ifdef MAC_SATURATE_EN
        if (o) begin
            s = a[ACC_W-1] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
        end
`endif
        return {o, s};
    endfunction

    assign prod_ready = (state_q != DRAIN);
    assign accept     = mac_if.prod_valid_i & prod_ready;
    assign final_acc  = accept & (cnt_q == 8'(BLOCK_LEN - 1));
    // A clear in the same cycle as the final accept discards the block.
    assign ser_load   = final_acc & ~mac_if.clear_i;
    assign prod_ext   = ACC_W'(sext_prod(MAX_W'($unsigned(mac_if.prod_i)), PROD_W));

    // Next accumulator value and sticky overflow for the product on the bus.
    always_comb begin
        {add_ovf, sum_d} = add_sat(acc_q, prod_ext);
        acc_d            = sum_d;
`ifdef MAC_SATURATE_EN
        // Once clamped, the block stays pinned at the limit.
        if (ovf_blk_q) acc_d = acc_q;
`endif
        ovf_blk_d = ovf_blk_q | add_ovf;
    end

    // Block FSM: accumulate BLOCK_LEN products, hand off to the serializer, wait for drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_blk_q <= 1'b0;
        end else if (mac_if.clear_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_blk_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (final_acc) begin
                        state_q   <= DRAIN;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        ovf_blk_q <= 1'b0;
                    end else if (accept) begin
                        state_q   <= ACC;
                        acc_q     <= acc_d;
                        cnt_q     <= cnt_q + 8'd1;
                        ovf_blk_q <= ovf_blk_d;
                    end
                end
                DRAIN: begin
                    if (ser_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    byte_serializer #(
        .ACC_W (ACC_W)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .clear_i (mac_if.clear_i),
        .load_i  (ser_load),
        .data_i  (acc_d),
        .ovf_i   (ovf_blk_d),
        .ready_i (mac_if.byte_ready_i),
        .byte_o  (mac_if.byte_o),
        .valid_o (mac_if.byte_valid_o),
        .ovf_o   (mac_if.ovf_o),
        .done_o  (ser_done)
    );

    assign mac_if.prod_ready_o = prod_ready;
    assign mac_if.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: dut_a uses default widths, dut_b uses
// ACC_W=16 for the overflow vectors. Expected bytes are queued when a block is
// issued; a negedge monitor pops and compares every accepted output byte.
module tb_mac_accumulator;

    typedef struct packed {
        logic [7:0] b;
        logic       o;
    } exp_t;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ma;
    exp_t mb;
    logic vld_before_last;

    mac_accumulator_if #(.PROD_W(16)) ifa ();
    mac_accumulator_if #(.PROD_W(16)) ifb ();

    mac_accumulator #(.PROD_W(16), .ACC_W(24), .BLOCK_LEN(4)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .mac_if (ifa.slave)
    );

    mac_accumulator #(.PROD_W(16), .ACC_W(16), .BLOCK_LEN(4)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .mac_if (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte is checked against the head of its queue.
    always @(negedge clk) begin
        if (!rst && ifa.byte_valid_o && ifa.byte_ready_i) begin
            if (qa.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL a_unexpected_byte: got %0h, expected no byte", ifa.byte_o);
            end else begin
                ma = qa.pop_front();
                check("a_byte", {24'd0, ifa.byte_o}, {24'd0, ma.b});
                check("a_ovf", {31'd0, ifa.ovf_o}, {31'd0, ma.o});
            end
        end
        if (!rst && ifb.byte_valid_o && ifb.byte_ready_i) begin
            if (qb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL b_unexpected_byte: got %0h, expected no byte", ifb.byte_o);
            end else begin
                mb = qb.pop_front();
                check("b_byte", {24'd0, ifb.byte_o}, {24'd0, mb.b});
                check("b_ovf", {31'd0, ifb.ovf_o}, {31'd0, mb.o});
            end
        end
    end

    task automatic push3(input bit sel, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic o);
        if (sel) begin
            qb.push_back('{b: b0, o: o});
            qb.push_back('{b: b1, o: o});
        end else begin
            qa.push_back('{b: b0, o: o});
            qa.push_back('{b: b1, o: o});
            qa.push_back('{b: b2, o: o});
        end
    endtask

    task automatic wait_ready(input bit sel);
        int n;
        n = 0;
        while (!(sel ? ifb.prod_ready_o : ifa.prod_ready_o) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(sel ? "b_ready_wait" : "a_ready_wait",
              {31'd0, (sel ? ifb.prod_ready_o : ifa.prod_ready_o)}, 32'd1);
    endtask

    task automatic send_one(input bit sel, input logic [15:0] p);
        if (sel) begin
            ifb.prod_i       = p;
            ifb.prod_valid_i = 1'b1;
        end else begin
            ifa.prod_i       = p;
            ifa.prod_valid_i = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input bit sel, input logic [15:0] p0, input logic [15:0] p1,
                              input logic [15:0] p2, input logic [15:0] p3);
        logic [15:0] p [4];
        p = '{p0, p1, p2, p3};
        wait_ready(sel);
        for (int i = 0; i < 4; i++) begin
            send_one(sel, p[i]);
            if (i == 2) vld_before_last = sel ? ifb.byte_valid_o : ifa.byte_valid_o;
        end
        ifa.prod_valid_i = 1'b0;
        ifb.prod_valid_i = 1'b0;
    endtask

    initial begin
        int n;
        nvec = 0;
        nerr = 0;
        vld_before_last = 1'b0;
        rst = 1'b1;
        ifa.prod_i = '0; ifa.prod_valid_i = 1'b0; ifa.clear_i = 1'b0; ifa.byte_ready_i = 1'b1;
        ifb.prod_i = '0; ifb.prod_valid_i = 1'b0; ifb.clear_i = 1'b0; ifb.byte_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_prod_ready", {31'd0, ifa.prod_ready_o}, 32'd1);
        check("rst_byte_valid", {31'd0, ifa.byte_valid_o}, 32'd0);
        check("rst_byte", {24'd0, ifa.byte_o}, 32'd0);
        check("rst_ovf", {31'd0, ifa.ovf_o}, 32'd0);
        check("rst_busy", {31'd0, ifa.busy_o}, 32'd0);
        check("rst_b_prod_ready", {31'd0, ifb.prod_ready_o}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1+2+3+4 = 10; latency and ready-low window
        push3(1'b0, 8'h0A, 8'h00, 8'h00, 1'b0);
        send_block(1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        check("t1_valid_before_final", {31'd0, vld_before_last}, 32'd0);
        check("t1_valid_after_final", {31'd0, ifa.byte_valid_o}, 32'd1);
        check("t1_busy", {31'd0, ifa.busy_o}, 32'd1);
        n = 1;
        while (!ifa.prod_ready_o && n < 20) begin
            @(posedge clk);
            #1;
            if (!ifa.prod_ready_o) n++;
        end
        check("t1_ready_low_cycles", n, 32'd3);
        check("t1_valid_after_drain", {31'd0, ifa.byte_valid_o}, 32'd0);
        check("t1_ovf_after_drain", {31'd0, ifa.ovf_o}, 32'd0);

        // Backpressure: sum 10 held on the pins, products offered meanwhile are ignored
        ifa.byte_ready_i = 1'b0;
        push3(1'b0, 8'h0A, 8'h00, 8'h00, 1'b0);
        send_block(1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        ifa.prod_i       = 16'h0077;
        ifa.prod_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t3_hold_byte", {24'd0, ifa.byte_o}, 32'h0A);
            check("t3_hold_valid", {31'd0, ifa.byte_valid_o}, 32'd1);
            check("t3_hold_ready", {31'd0, ifa.prod_ready_o}, 32'd0);
        end
        ifa.prod_valid_i = 1'b0;
        ifa.byte_ready_i = 1'b1;

        // Four times -1 = -4
        push3(1'b0, 8'hFC, 8'hFF, 8'hFF, 1'b0);
        send_block(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

        // ACC_W=16 overflow: 0x7FFF + 1
`ifdef MAC_SATURATE_EN
        push3(1'b1, 8'hFF, 8'h7F, 8'h00, 1'b1);
`else
        push3(1'b1, 8'h00, 8'h80, 8'h00, 1'b1);
`endif
        send_block(1'b1, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000);
        wait_ready(1'b1);
        check("t4_b_ovf_cleared", {31'd0, ifb.ovf_o}, 32'd0);

        // Clear after two accepts, clear also wins over a simultaneous accept
        wait_ready(1'b0);
        send_one(1'b0, 16'h0100);
        send_one(1'b0, 16'h0100);
        ifa.clear_i = 1'b1;
        send_one(1'b0, 16'h0100);
        ifa.clear_i      = 1'b0;
        ifa.prod_valid_i = 1'b0;
        check("t5_busy_after_clear", {31'd0, ifa.busy_o}, 32'd0);
        check("t5_ready_after_clear", {31'd0, ifa.prod_ready_o}, 32'd1);
        push3(1'b0, 8'h14, 8'h00, 8'h00, 1'b0);
        send_block(1'b0, 16'h0005, 16'h0005, 16'h0005, 16'h0005);

        // Reset in DRAIN after the first byte of a 3*4=12 block
        wait_ready(1'b0);
        ifa.byte_ready_i = 1'b0;
        qa.push_back('{b: 8'h0C, o: 1'b0});
        send_block(1'b0, 16'h0003, 16'h0003, 16'h0003, 16'h0003);
        ifa.byte_ready_i = 1'b1;
        @(posedge clk);
        #1;
        ifa.byte_ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, ifa.byte_valid_o}, 32'd0);
        check("t6_rst_ready", {31'd0, ifa.prod_ready_o}, 32'd1);
        check("t6_rst_busy", {31'd0, ifa.busy_o}, 32'd0);
        check("t6_rst_byte", {24'd0, ifa.byte_o}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        ifa.byte_ready_i = 1'b1;
        push3(1'b0, 8'h08, 8'h00, 8'h00, 1'b0);
        send_block(1'b0, 16'h0002, 16'h0002, 16'h0002, 16'h0002);
        wait_ready(1'b0);

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("a_queue_drained", qa.size(), 32'd0);
        check("b_queue_drained", qb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
